// File: rtl/ldd_pkg.sv
// Shared types and defaults for the LDD write-disable scheduling logic.
package ldd_pkg;

   localparam int LDD_CH_DEFAULT    = 3;
   localparam int GUARD_CYC_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COM,
      ST_G2CAP,
      ST_PULSE,
      ST_GAP,
      ST_G2COM
   } ldd_sched_st_t;

   // States in which the capture sequence owns the output stage
   function automatic logic st_is_cap(input ldd_sched_st_t s);
      return (s == ST_G2CAP) || (s == ST_PULSE) || (s == ST_GAP) || (s == ST_G2COM);
   endfunction

endpackage

// File: rtl/ldd_ch_pick.sv
// Finds the lowest set mask bit strictly above cur (or at/above 0 when first=1).
module ldd_ch_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] cur,
   input  logic          first,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Descending scan so the lowest qualifying bit is the one that sticks
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i] && (first || (i > int'(cur)))) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ldd_wdis_sched.sv
// WDIS scheduler: passes the communication WDIS through, or runs guarded
// one-channel-at-a-time capture enable pulses, with all outputs registered.
module ldd_wdis_sched
   import ldd_pkg::*;
#(
   parameter int TOP0_0    = LDD_CH_DEFAULT,
   parameter int GUARD_CYC = GUARD_CYC_DEFAULT,
   parameter int PW_W      = 16
) (
   input  logic              clk200,
   input  logic              rst,
   input  logic              com_req,
   input  logic [TOP0_0-1:0] com_wdis_in,
   output logic              com_gnt,
   input  logic              cap_req,
   input  logic [TOP0_0-1:0] cap_ch_mask,
   input  logic [PW_W-1:0]   cap_pw,
   output logic              cap_busy,
   output logic              cap_done,
   output logic              cap_err,
   output logic              cap_mode,
   output logic [TOP0_0-1:0] cap_wdis,
   output logic [TOP0_0-1:0] com_wdis
);

   localparam int GW = $clog2(GUARD_CYC + 1);
   localparam int IW = (TOP0_0 > 1) ? $clog2(TOP0_0) : 1;
   localparam logic [GW-1:0] G_LOAD = GW'(GUARD_CYC - 1);

   ldd_sched_st_t     st, st_nxt;
   logic [GW-1:0]     gcnt, gcnt_nxt;
   logic [PW_W-1:0]   pcnt, pcnt_nxt;
   logic [PW_W-1:0]   pw_l, pw_nxt, pw_ld;
   logic [TOP0_0-1:0] mask_l, mask_nxt;
   logic [IW-1:0]     ch, ch_nxt;
   logic [IW-1:0]     pick_idx;
   logic              pick_vld;
   logic              pick_first;
   logic              accept;
   logic              done_nxt;
   logic              err_nxt;
   logic [TOP0_0-1:0] wdis_nxt;

   assign pick_first = (st == ST_G2CAP);
   assign accept     = cap_req && (cap_ch_mask != '0);
   // A zero pulse length still yields a one-cycle enable
   assign pw_ld      = (pw_l == '0) ? '0 : pw_l - PW_W'(1);

   ldd_ch_pick #(.N(TOP0_0), .IW(IW)) u_pick (
      .mask  (mask_l),
      .cur   (ch),
      .first (pick_first),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   always_comb begin
      st_nxt   = st;
      gcnt_nxt = gcnt;
      pcnt_nxt = pcnt;
      pw_nxt   = pw_l;
      mask_nxt = mask_l;
      ch_nxt   = ch;
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
      wdis_nxt = '1;
      case (st)
         ST_IDLE, ST_COM: begin
            if (cap_req && (cap_ch_mask == '0)) done_nxt = 1'b1;
            if (accept) begin
               st_nxt   = ST_G2CAP;
               gcnt_nxt = G_LOAD;
               mask_nxt = cap_ch_mask;
               pw_nxt   = cap_pw;
            end else begin
               st_nxt = com_req ? ST_COM : ST_IDLE;
            end
         end
         ST_G2CAP, ST_GAP: begin
            err_nxt = cap_req;
            if (gcnt == '0) begin
               st_nxt   = ST_PULSE;
               ch_nxt   = pick_idx;
               pcnt_nxt = pw_ld;
            end else begin
               gcnt_nxt = gcnt - GW'(1);
            end
         end
         ST_PULSE: begin
            err_nxt = cap_req;
            if (pcnt == '0) begin
               gcnt_nxt = G_LOAD;
               st_nxt   = pick_vld ? ST_GAP : ST_G2COM;
            end else begin
               pcnt_nxt = pcnt - PW_W'(1);
            end
         end
         ST_G2COM: begin
            err_nxt = cap_req;
            if (gcnt == '0) st_nxt = com_req ? ST_COM : ST_IDLE;
            else            gcnt_nxt = gcnt - GW'(1);
         end
         default: st_nxt = ST_IDLE;
      endcase
      // cap_done is registered, so it is raised on entry to the final guard cycle
      if ((st_nxt == ST_G2COM) && (gcnt_nxt == '0)) done_nxt = 1'b1;
      if (st_nxt == ST_PULSE) wdis_nxt[ch_nxt] = 1'b0;
   end

   always_ff @(posedge clk200) begin
      if (rst) begin
         st       <= ST_IDLE;
         gcnt     <= '0;
         pcnt     <= '0;
         pw_l     <= '0;
         mask_l   <= '0;
         ch       <= '0;
         cap_mode <= 1'b0;
         cap_busy <= 1'b0;
         cap_done <= 1'b0;
         cap_err  <= 1'b0;
         com_gnt  <= 1'b0;
         cap_wdis <= '1;
         com_wdis <= '1;
      end else begin
         st       <= st_nxt;
         gcnt     <= gcnt_nxt;
         pcnt     <= pcnt_nxt;
         pw_l     <= pw_nxt;
         mask_l   <= mask_nxt;
         ch       <= ch_nxt;
         cap_mode <= st_is_cap(st_nxt);
         cap_busy <= st_is_cap(st_nxt);
         cap_done <= done_nxt;
         cap_err  <= err_nxt;
         com_gnt  <= (st_nxt == ST_COM);
         cap_wdis <= wdis_nxt;
         com_wdis <= (st_nxt == ST_COM) ? com_wdis_in : '1;
      end
   end

endmodule

// File: tb/tb_ldd_wdis_sched.sv
// Bench for ldd_wdis_sched: directed scenarios plus random traffic against a
// timeline model that computes pulse windows arithmetically from the request.
module tb_ldd_wdis_sched;

   localparam int N    = 3;
   localparam int G    = 16;
   localparam int PW_W = 16;

   logic            clk200 = 1'b0;
   logic            rst = 1'b1;
   logic            com_req = 1'b0;
   logic [N-1:0]    com_wdis_in = '0;
   logic            com_gnt;
   logic            cap_req = 1'b0;
   logic [N-1:0]    cap_ch_mask = '0;
   logic [PW_W-1:0] cap_pw = '0;
   logic            cap_busy;
   logic            cap_done;
   logic            cap_err;
   logic            cap_mode;
   logic [N-1:0]    cap_wdis;
   logic [N-1:0]    com_wdis;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // model state
   bit           m_active = 1'b0;
   bit           m_com = 1'b0;
   int           m_c = 0;
   int           m_done_at = 0;
   int           m_pw = 1;
   logic [N-1:0] m_mask = '0;
   // expected outputs for the cycle after the current edge
   logic         e_mode, e_busy, e_done, e_err, e_gnt;
   logic [N-1:0] e_capw, e_comw;

   always #5 clk200 = ~clk200;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   ldd_wdis_sched #(.TOP0_0(N), .GUARD_CYC(G), .PW_W(PW_W)) dut (
      .clk200      (clk200),
      .rst         (rst),
      .com_req     (com_req),
      .com_wdis_in (com_wdis_in),
      .com_gnt     (com_gnt),
      .cap_req     (cap_req),
      .cap_ch_mask (cap_ch_mask),
      .cap_pw      (cap_pw),
      .cap_busy    (cap_busy),
      .cap_done    (cap_done),
      .cap_err     (cap_err),
      .cap_mode    (cap_mode),
      .cap_wdis    (cap_wdis),
      .com_wdis    (com_wdis)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance the model by one cycle using the inputs presented in cycle n
   task automatic model_step();
      int n, t, k, s, cnt;
      n = cyc;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         m_com    = 1'b0;
      end else if (m_active) begin
         e_err = cap_req;
         if (n == m_done_at) begin
            m_active = 1'b0;
            m_com    = com_req;
         end
      end else if (cap_req && (cap_ch_mask != '0)) begin
         cnt       = $countones(cap_ch_mask);
         m_active  = 1'b1;
         m_com     = 1'b0;
         m_c       = n;
         m_mask    = cap_ch_mask;
         m_pw      = (cap_pw == '0) ? 1 : int'(cap_pw);
         m_done_at = n + cnt * m_pw + (cnt + 1) * G;
      end else begin
         if (cap_req) e_done = 1'b1;
         m_com = com_req;
      end
      if (m_active && (n + 1 == m_done_at)) e_done = 1'b1;
      e_mode = m_active;
      e_busy = m_active;
      e_gnt  = !m_active && m_com;
      e_comw = (!rst && e_gnt) ? com_wdis_in : '1;
      e_capw = '1;
      if (m_active) begin
         t = (n + 1) - (m_c + 1);
         k = 0;
         for (int i = 0; i < N; i++) begin
            if (m_mask[i]) begin
               s = G + k * (m_pw + G);
               if ((t >= s) && (t < s + m_pw)) e_capw[i] = 1'b0;
               k++;
            end
         end
      end
   endtask

   task automatic tick();
      logic inv_ok;
      @(posedge clk200);
      model_step();
      #1;
      chk("cap_mode", 32'(cap_mode), 32'(e_mode));
      chk("cap_busy", 32'(cap_busy), 32'(e_busy));
      chk("cap_done", 32'(cap_done), 32'(e_done));
      chk("cap_err",  32'(cap_err),  32'(e_err));
      chk("com_gnt",  32'(com_gnt),  32'(e_gnt));
      chk("cap_wdis", 32'(cap_wdis), 32'(e_capw));
      chk("com_wdis", 32'(com_wdis), 32'(e_comw));
      chk("one_low", 32'($countones(~cap_wdis) <= 1), 32'(1));
      inv_ok = !((cap_mode || !com_gnt) && (com_wdis != '1));
      chk("com_gate", 32'(inv_ok), 32'(1));
      cyc++;
   endtask

   task automatic req_cap(input logic [N-1:0] mask, input logic [PW_W-1:0] pw);
      cap_req     = 1'b1;
      cap_ch_mask = mask;
      cap_pw      = pw;
      tick();
      cap_req     = 1'b0;
      cap_ch_mask = '0;
      cap_pw      = '0;
   endtask

   initial begin
      int waited, low_cnt, oc;
      logic done_seen;

      // reset
      repeat (3) tick();
      chk("rst_mode", 32'(cap_mode), 32'(0));
      chk("rst_capw", 32'(cap_wdis), 32'(3'b111));
      chk("rst_comw", 32'(com_wdis), 32'(3'b111));
      rst = 1'b0;
      tick();

      // communication only
      com_req     = 1'b1;
      com_wdis_in = 3'b010;
      tick();
      chk("com_gnt_on", 32'(com_gnt), 32'(1));
      chk("com_pass", 32'(com_wdis), 32'(3'b010));
      com_wdis_in = 3'b101;
      tick();
      chk("com_pass2", 32'(com_wdis), 32'(3'b101));
      com_req = 1'b0;
      tick();
      chk("com_drop", 32'(com_wdis), 32'(3'b111));
      tick();

      // capture: mask 101, pw 4
      req_cap(3'b101, 16'd4);
      oc = 1;
      while (oc <= 60) begin
         chk("dir_ch0", 32'(!cap_wdis[0]), 32'((oc >= 17) && (oc <= 20)));
         chk("dir_ch2", 32'(!cap_wdis[2]), 32'((oc >= 37) && (oc <= 40)));
         chk("dir_done", 32'(cap_done), 32'(oc == 56));
         chk("dir_mode", 32'(cap_mode), 32'((oc >= 1) && (oc <= 56)));
         tick();
         oc++;
      end

      // preempt from COM, mask 010, pw 0
      com_req = 1'b1;
      repeat (3) begin
         com_wdis_in = 3'($urandom_range(0, 7));
         tick();
      end
      req_cap(3'b010, 16'd0);
      chk("pre_gnt_drop", 32'(com_gnt), 32'(0));
      low_cnt = 0;
      waited = 0;
      while (cap_busy && (waited < 200)) begin
         if (!cap_wdis[1]) low_cnt++;
         tick();
         waited++;
      end
      chk("pre_timeout", 32'(waited < 200), 32'(1));
      chk("pre_len", 32'(waited), 32'(2 * G + 1));
      chk("pre_low_cnt", 32'(low_cnt), 32'(1));
      chk("pre_back_com", 32'(com_gnt), 32'(1));
      com_req = 1'b0;
      repeat (2) tick();

      // cap_req while busy, then mask=0
      req_cap(3'b011, 16'd2);
      repeat (4) tick();
      req_cap(3'b100, 16'd7);
      chk("err_pulse", 32'(cap_err), 32'(1));
      waited = 0;
      while (cap_busy && (waited < 200)) begin
         tick();
         waited++;
      end
      chk("err_timeout", 32'(waited < 200), 32'(1));
      chk("err_busy_len", 32'(6 + waited - 1), 32'(2 * 2 + 3 * G));
      tick();
      req_cap(3'b000, 16'd3);
      chk("m0_done", 32'(cap_done), 32'(1));
      chk("m0_mode", 32'(cap_mode), 32'(0));
      tick();
      chk("m0_done_off", 32'(cap_done), 32'(0));

      // reset in the middle of a pulse
      req_cap(3'b001, 16'd8);
      repeat (17) tick();
      chk("rst_in_pulse", 32'(cap_wdis), 32'(3'b110));
      rst = 1'b1;
      tick();
      chk("rst_mid_capw", 32'(cap_wdis), 32'(3'b111));
      chk("rst_mid_busy", 32'(cap_busy), 32'(0));
      chk("rst_mid_mode", 32'(cap_mode), 32'(0));
      repeat (2) tick();
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (60) begin
         tick();
         done_seen = done_seen | cap_done;
      end
      chk("rst_no_done", 32'(done_seen), 32'(0));

      // random traffic
      repeat (3000) begin
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 19) == 0) com_req = ~com_req;
         com_wdis_in = 3'($urandom_range(0, 7));
         cap_req     = ($urandom_range(0, 29) == 0);
         cap_ch_mask = 3'($urandom_range(0, 7));
         cap_pw      = 16'($urandom_range(0, 5));
         tick();
      end
      rst = 1'b0;
      cap_req = 1'b0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
